// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller driving one external full-adder cell.
//
// Operands are shifted out LSB first, one bit per clock, into an external full adder.
// The cell's sum bit is shifted back in, and its carry is fed back on the next cycle.
// An operation takes WIDTH RUN cycles followed by one DONE cycle.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start               request, accepted only in IDLE
//   op_a, op_b, cin     operands and initial carry, sampled on the accepting edge
//   fa_a, fa_b, fa_cin  bit-serial drive into the full-adder cell
//   fa_sum, fa_cout     full-adder cell outputs
//   busy                high in RUN and DONE
//   done                one-cycle pulse when the result is valid
//   sum, cout, ovf      registered result, final carry and signed overflow;
//                       held until the next operation completes

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] CntPen  = CntW'(WIDTH - 2);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              cmsb_q, cmsb_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            cmsb_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            cmsb_q   <= cmsb_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        cmsb_d   = cmsb_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        fa_a     = 1'b0;
        fa_b     = 1'b0;
        fa_cin   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d      = op_a;
                    b_d      = op_b;
                    carry_d  = cin;
                    cnt_d    = '0;
                    sum_sh_d = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                busy     = 1'b1;
                fa_a     = a_q[0];
                fa_b     = b_q[0];
                fa_cin   = carry_q;
                sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
                carry_d  = fa_cout;
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                // Carry out of bit WIDTH-2 is the carry into the sign bit.
                if (cnt_q == CntPen) begin
                    cmsb_d = fa_cout;
                end
                if (cnt_q == CntLast) begin
                    sum_d   = {fa_sum, sum_sh_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    ovf_d   = fa_cout ^ cmsb_q;
                    state_d = StDone;
                end
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and random bench for serial_adder_ctrl at WIDTH=4 and 8.
// Each instance drives its own behavioural full-adder cell. Expected results are queued
// when an operation is accepted and are compared when done pulses.

module tb_serial_adder_ctrl;

    typedef struct packed {
        logic       cout;
        logic       ovf;
        logic [7:0] sum;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // WIDTH=4 instance
    logic       start4, cin4, fa_a4, fa_b4, fa_cin4, fa_sum4, fa_cout4;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] op_a4, op_b4, sum4;

    // WIDTH=8 instance
    logic       start8, cin8, fa_a8, fa_b8, fa_cin8, fa_sum8, fa_cout8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] op_a8, op_b8, sum8;

    assign fa_sum4  = fa_a4 ^ fa_b4 ^ fa_cin4;
    assign fa_cout4 = (fa_a4 & fa_b4) | (fa_a4 & fa_cin4) | (fa_b4 & fa_cin4);
    assign fa_sum8  = fa_a8 ^ fa_b8 ^ fa_cin8;
    assign fa_cout8 = (fa_a8 & fa_b8) | (fa_a8 & fa_cin8) | (fa_b8 & fa_cin8);

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start4),
        .op_a    (op_a4),
        .op_b    (op_b4),
        .cin     (cin4),
        .fa_a    (fa_a4),
        .fa_b    (fa_b4),
        .fa_cin  (fa_cin4),
        .fa_sum  (fa_sum4),
        .fa_cout (fa_cout4),
        .busy    (busy4),
        .done    (done4),
        .sum     (sum4),
        .cout    (cout4),
        .ovf     (ovf4)
    );

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start8),
        .op_a    (op_a8),
        .op_b    (op_b8),
        .cin     (cin8),
        .fa_a    (fa_a8),
        .fa_b    (fa_b8),
        .fa_cin  (fa_cin8),
        .fa_sum  (fa_sum8),
        .fa_cout (fa_cout8),
        .busy    (busy8),
        .done    (done8),
        .sum     (sum8),
        .cout    (cout8),
        .ovf     (ovf8)
    );

    int   tests = 0;
    int   fails = 0;
    int   dcnt4 = 0;
    res_t q4[$];
    res_t q8[$];

    always @(posedge clk) begin
        if (done4 === 1'b1) dcnt4 <= dcnt4 + 1;
    end

    // Reference: full-width addition; overflow from operand and result signs.
    function automatic res_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                   input logic c);
        logic [8:0] full;
        res_t       r;
        full   = {1'b0, a} + {1'b0, b} + {8'd0, c};
        r.sum  = full[7:0] & 8'((1 << w) - 1);
        r.cout = full[w];
        r.ovf  = (a[w-1] == b[w-1]) && (full[w-1] != a[w-1]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pop4(input string tag);
        res_t e;
        if (q4.size() == 0) begin
            chk({tag, "_underflow"}, q4.size(), 1);
        end else begin
            e = q4.pop_front();
            chk({tag, "_res"}, {cout4, ovf4, sum4}, {e.cout, e.ovf, e.sum[3:0]});
        end
    endtask

    // Called at the negedge after the accepting edge; n = edges until done is seen.
    task automatic wait_done4(output int n, output logic [7:0] tr);
        n  = 0;
        tr = '0;
        while (done4 !== 1'b1 && n < 40) begin
            if (n < 8) tr[n] = fa_cin4;
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            chk("done4_timeout", n, 0);
        end else begin
            chk("done4_fa_zero", {fa_a4, fa_b4, fa_cin4}, 0);
            pop4("op4");
            @(negedge clk);
            chk("done4_pulse", {busy4, done4}, 0);
        end
    endtask

    // lat = index of the edge that captures done, counting the accepting edge as 0.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c,
                        output int lat, output logic [7:0] tr);
        int n;
        @(negedge clk);
        op_a4 = a; op_b4 = b; cin4 = c; start4 = 1'b1;
        q4.push_back(model(4, {4'b0, a}, {4'b0, b}, c));
        @(negedge clk);
        start4 = 1'b0;
        op_a4 = ~a; op_b4 = ~b; cin4 = ~c;
        wait_done4(n, tr);
        lat = n + 1;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c);
        res_t e;
        int   n;
        int   nb;
        bit   seen;
        @(negedge clk);
        op_a8 = a; op_b8 = b; cin8 = c; start8 = 1'b1;
        q8.push_back(model(8, a, b, c));
        @(negedge clk);
        start8 = 1'b0;
        op_a8 = ~a; op_b8 = ~b; cin8 = ~c;
        n = 0; nb = 0; seen = 1'b0;
        while (busy8 === 1'b1 && n < 40) begin
            nb++;
            if (done8 === 1'b1) begin
                seen = 1'b1;
                if (q8.size() == 0) begin
                    chk("q8_underflow", q8.size(), 1);
                end else begin
                    e = q8.pop_front();
                    chk("res8", {cout8, ovf8, sum8}, {e.cout, e.ovf, e.sum});
                end
            end
            @(negedge clk);
            n++;
        end
        chk("busy8_cycles", nb, 9);
        chk("done8_seen", seen, 1);
    endtask

    initial begin
        int         lat;
        int         d0;
        logic [7:0] tr;

        rst_n = 1'b0;
        start4 = 1'b0; op_a4 = '0; op_b4 = '0; cin4 = 1'b0;
        start8 = 1'b0; op_a8 = '0; op_b8 = '0; cin8 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst4_outs", {busy4, done4, cout4, ovf4, fa_a4, fa_b4, fa_cin4, sum4}, 0);
        chk("rst8_outs", {busy8, done8, cout8, ovf8, fa_a8, fa_b8, fa_cin8, sum8}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Signed overflow from two positives; latency check.
        run4(4'b0011, 4'b0101, 1'b0, lat, tr);
        chk("t1_latency", lat, 5);

        // Carry ripples through every bit.
        run4(4'b1111, 4'b0001, 1'b0, lat, tr);
        chk("t2_fa_cin_seq", tr[3:0], 4'b1110);

        run4(4'b0000, 4'b0000, 1'b1, lat, tr);
        run4(4'b1000, 4'b1000, 1'b0, lat, tr);

        // start ignored in RUN and DONE; next accept at edge 6.
        @(negedge clk);
        op_a4 = 4'b0110; op_b4 = 4'b0001; cin4 = 1'b0; start4 = 1'b1;
        q4.push_back(model(4, 8'b0110, 8'b0001, 1'b0));
        d0 = dcnt4;
        @(negedge clk);
        start4 = 1'b0; op_a4 = 4'hf; op_b4 = 4'hf;
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        chk("t4_run_no_done", {busy4, done4}, 2'b10);
        @(negedge clk);
        chk("t4_done", done4, 1);
        pop4("t4");
        start4 = 1'b1; op_a4 = 4'b0011; op_b4 = 4'b0100; cin4 = 1'b0;
        @(negedge clk);
        chk("t4_ignored_in_done", busy4, 0);
        chk("t4_one_done", dcnt4 - d0, 1);
        q4.push_back(model(4, 8'b0011, 8'b0100, 1'b0));
        @(negedge clk);
        chk("t4_accept_edge6", busy4, 1);
        start4 = 1'b0;
        wait_done4(lat, tr);

        // Reset mid-RUN aborts and clears the held result.
        @(negedge clk);
        op_a4 = 4'hf; op_b4 = 4'hf; cin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        d0 = dcnt4;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_async", {busy4, done4, cout4, ovf4, sum4}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("t5_no_done", dcnt4 - d0, 0);
        chk("t5_idle", {busy4, sum4}, 0);
        run4(4'b0010, 4'b0010, 1'b0, lat, tr);

        // WIDTH=8 corners and random triples.
        run8(8'h7f, 8'h01, 1'b0);
        run8(8'hff, 8'hff, 1'b1);
        run8(8'h80, 8'h80, 1'b0);
        run8(8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        chk("q4_drained", q4.size(), 0);
        chk("q8_drained", q8.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
